// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Register-file write-port arbiter. The pipeline writeback has
//               strict priority; a long-latency unit is buffered in a FIFO that
//               drains on idle pipeline cycles. Exports a busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_valid_i,
    input  logic [4:0]    pipe_reg_i,
    input  logic [31:0]   pipe_data_i,
    input  logic          aux_valid_i,
    output logic          aux_ready_o,
    input  logic [4:0]    aux_reg_i,
    input  logic [31:0]   aux_data_i,
    output logic          reg_write_o,
    output logic [4:0]    write_reg_o,
    output logic [31:0]   write_data_o,
    output logic [31:0]   busy_mask_o,
    output logic [AW:0]   pending_cnt_o
);

    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

    logic [4:0]       fifo_reg_q  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    logic             reg_write_q;
    logic [4:0]       write_reg_q;
    logic [31:0]      write_data_q;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_busy;

    // Ready is a function of registered occupancy only; a same-cycle pop
    // never reopens it.
    assign aux_ready_o = !rst && (count_q < c_DEPTH_CNT);
    assign w_accept    = aux_valid_i && aux_ready_o;
    assign w_push      = w_accept && (aux_reg_i != 5'd0);
    assign w_pop       = (count_q != '0) && !pipe_valid_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fifo_vld_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Push and pop never target the same slot: a push needs a free
            // slot and a pop needs an occupied one.
            if (w_pop) begin
                fifo_vld_q[rd_ptr_q] <= 1'b0;
            end
            if (w_push) begin
                fifo_vld_q[wr_ptr_q]  <= 1'b1;
                fifo_reg_q[wr_ptr_q]  <= aux_reg_i;
                fifo_data_q[wr_ptr_q] <= aux_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
        end else if (pipe_valid_i) begin
            reg_write_q  <= (pipe_reg_i != 5'd0);
            write_reg_q  <= pipe_reg_i;
            write_data_q <= pipe_data_i;
        end else if (w_pop) begin
            reg_write_q  <= 1'b1;
            write_reg_q  <= fifo_reg_q[rd_ptr_q];
            write_data_q <= fifo_data_q[rd_ptr_q];
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

    always_comb begin
        w_busy = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld_q[i]) begin
                w_busy[fifo_reg_q[i]] = 1'b1;
            end
        end
        if (reg_write_q) begin
            w_busy[write_reg_q] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign reg_write_o   = reg_write_q;
    assign write_reg_o   = write_reg_q;
    assign write_data_o  = write_data_q;
    assign busy_mask_o   = w_busy;
    assign pending_cnt_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Directed scoreboard bench for wb_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_reg;
    logic [31:0] aux_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] busy_mask;
    logic [2:0]  pending_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic        mon_en = 1'b0;
    logic [36:0] exp_q[$];

    wb_write_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid_i  (pipe_valid),
        .pipe_reg_i    (pipe_reg),
        .pipe_data_i   (pipe_data),
        .aux_valid_i   (aux_valid),
        .aux_ready_o   (aux_ready),
        .aux_reg_i     (aux_reg),
        .aux_data_i    (aux_data),
        .reg_write_o   (reg_write),
        .write_reg_o   (write_reg),
        .write_data_o  (write_data),
        .busy_mask_o   (busy_mask),
        .pending_cnt_o (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Commit monitor: every regfile write must match the next expected commit.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_bit0", {31'd0, busy_mask[0]}, 32'd0);
            if (reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_commit: got reg %0d data %h expected no write",
                             write_reg, write_data);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("commit_reg", {27'd0, write_reg}, {27'd0, e[36:32]});
                    chk("commit_data", write_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pipe_valid = 1'b0; pipe_reg = '0; pipe_data = '0;
        aux_valid = 1'b0; aux_reg = '0; aux_data = '0;
        step();
        step();
        chk("rst_ready", {31'd0, aux_ready}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_pending", {29'd0, pending_cnt}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, aux_ready}, 32'd1);

        // Pipe path
        pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h1234;
        exp_push(5'd5, 32'h1234);
        step();
        chk("pipe_rw", {31'd0, reg_write}, 32'd1);
        chk("pipe_reg", {27'd0, write_reg}, 32'd5);
        chk("pipe_data", write_data, 32'h1234);
        pipe_reg = 5'd0; pipe_data = 32'h55;
        step();
        chk("pipe_r0_rw", {31'd0, reg_write}, 32'd0);
        pipe_valid = 1'b0;
        step();

        // Single aux push, minimum latency
        aux_valid = 1'b1; aux_reg = 5'd7; aux_data = 32'hDEADBEEF;
        exp_push(5'd7, 32'hDEADBEEF);
        step();
        aux_valid = 1'b0;
        chk("aux7_busy", {31'd0, busy_mask[7]}, 32'd1);
        chk("aux7_pending", {29'd0, pending_cnt}, 32'd1);
        chk("aux7_rw_n1", {31'd0, reg_write}, 32'd0);
        step();
        chk("aux7_rw", {31'd0, reg_write}, 32'd1);
        chk("aux7_reg", {27'd0, write_reg}, 32'd7);
        step();
        chk("aux7_busy_clr", {31'd0, busy_mask[7]}, 32'd0);

        // Aux starved while the pipeline writes for 5 cycles
        for (int i = 0; i < 5; i++) begin
            pipe_valid = 1'b1; pipe_reg = 5'(10 + i); pipe_data = 32'h100 + i;
            aux_valid = (i == 0); aux_reg = 5'd3; aux_data = 32'h33;
            exp_push(5'(10 + i), 32'h100 + i);
            step();
            aux_valid = 1'b0;
            chk("starve_pending", {29'd0, pending_cnt}, 32'd1);
            chk("starve_busy3", {31'd0, busy_mask[3]}, 32'd1);
        end
        pipe_valid = 1'b0;
        exp_push(5'd3, 32'h33);
        step();
        chk("starve_commit_reg", {27'd0, write_reg}, 32'd3);
        step();
        chk("starve_pending0", {29'd0, pending_cnt}, 32'd0);

        // Fill the FIFO while the pipeline holds the port
        for (int k = 1; k <= 4; k++) begin
            pipe_valid = 1'b1; pipe_reg = 5'd20; pipe_data = 32'h200 + k;
            aux_valid = 1'b1; aux_reg = 5'(k); aux_data = 32'hA000_0000 + k;
            exp_push(5'd20, 32'h200 + k);
            step();
        end
        chk("full_pending", {29'd0, pending_cnt}, 32'd4);
        chk("full_ready", {31'd0, aux_ready}, 32'd0);
        aux_reg = 5'd5; aux_data = 32'hA000_0005; pipe_data = 32'h205;
        exp_push(5'd20, 32'h205);
        step();
        chk("full_hold_pending", {29'd0, pending_cnt}, 32'd4);
        chk("full_hold_ready", {31'd0, aux_ready}, 32'd0);
        pipe_valid = 1'b0;
        for (int k = 1; k <= 5; k++) exp_push(5'(k), 32'hA000_0000 + k);
        step();
        chk("drain_reg1", {27'd0, write_reg}, 32'd1);
        chk("drain_ready", {31'd0, aux_ready}, 32'd1);
        step();
        aux_valid = 1'b0;
        chk("drain_reg2", {27'd0, write_reg}, 32'd2);
        step();
        chk("drain_reg3", {27'd0, write_reg}, 32'd3);
        step();
        chk("drain_reg4", {27'd0, write_reg}, 32'd4);
        step();
        chk("drain_reg5", {27'd0, write_reg}, 32'd5);
        chk("drain_pending0", {29'd0, pending_cnt}, 32'd0);
        step();
        chk("drain_idle_rw", {31'd0, reg_write}, 32'd0);

        // Simultaneous push and pop with two entries queued
        pipe_valid = 1'b1; pipe_reg = 5'd21; pipe_data = 32'h301;
        aux_valid = 1'b1; aux_reg = 5'd8; aux_data = 32'h88;
        exp_push(5'd21, 32'h301);
        step();
        pipe_data = 32'h302; aux_reg = 5'd6; aux_data = 32'h66;
        exp_push(5'd21, 32'h302);
        step();
        pipe_valid = 1'b0; aux_reg = 5'd9; aux_data = 32'h99;
        exp_push(5'd8, 32'h88);
        step();
        aux_valid = 1'b0;
        chk("pp_pending", {29'd0, pending_cnt}, 32'd2);
        chk("pp_reg8", {27'd0, write_reg}, 32'd8);
        chk("pp_busy9", {31'd0, busy_mask[9]}, 32'd1);
        exp_push(5'd6, 32'h66);
        exp_push(5'd9, 32'h99);
        step();
        chk("pp_reg6", {27'd0, write_reg}, 32'd6);
        step();
        chk("pp_reg9", {27'd0, write_reg}, 32'd9);
        chk("pp_pending0", {29'd0, pending_cnt}, 32'd0);
        step();

        // Push to r0 is accepted and dropped
        aux_valid = 1'b1; aux_reg = 5'd0; aux_data = 32'hBAD0;
        chk("r0_ready", {31'd0, aux_ready}, 32'd1);
        step();
        aux_valid = 1'b0;
        chk("r0_pending", {29'd0, pending_cnt}, 32'd0);
        step();
        chk("r0_rw", {31'd0, reg_write}, 32'd0);

        // Reset with three queued entries discards them
        for (int k = 0; k < 3; k++) begin
            pipe_valid = 1'b1; pipe_reg = 5'd22; pipe_data = 32'h400 + k;
            aux_valid = 1'b1; aux_reg = 5'(11 + k); aux_data = 32'hC00 + k;
            exp_push(5'd22, 32'h400 + k);
            step();
        end
        chk("prerst_pending", {29'd0, pending_cnt}, 32'd3);
        rst = 1'b1; pipe_valid = 1'b0; aux_valid = 1'b0;
        #1;
        chk("inrst_ready", {31'd0, aux_ready}, 32'd0);
        step();
        chk("mrst_pending", {29'd0, pending_cnt}, 32'd0);
        chk("mrst_busy", busy_mask, 32'd0);
        chk("mrst_rw", {31'd0, reg_write}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Post-reset push uses freshly reset pointers
        aux_valid = 1'b1; aux_reg = 5'd15; aux_data = 32'hF00D;
        exp_push(5'd15, 32'hF00D);
        step();
        aux_valid = 1'b0;
        step();
        chk("postrst_reg", {27'd0, write_reg}, 32'd15);
        chk("postrst_data", write_data, 32'hF00D);
        for (int k = 0; k < 3; k++) step();
        @(negedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
